nv_ram_rws_pinit: RTL
=====================

Name: nv_ram_rws_pinit

Overview:
Parametrised successor to the fixed-size 128x128 RWS (one read port, one write port, single clock) RAM model. Adds the following:
- Configurable width and depth.
- Per-lane write mask.
- Write-first read-during-write bypass.
- Optional output pipeline register.
- Self-clearing init sequencer that zeroes the array after reset.

It sits wherever datapath buffers need a synthesizable FPGA RAM model with deterministic contents after reset.

Parameters:
DW, 128, data width in bits.
AW, 7, address width in bits.
DEPTH, 128, number of words; legal range 2..2^AW.
MW, 8, write-mask lane width in bits; DW must be a multiple of MW.
OREG, 0, number of extra output registers; 0 gives read latency 1, 1 gives read latency 2.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous active-high reset.
ra  in  AW  read address.
re  in  1  read enable.
dout  out  DW  read data.
wa  in  AW  write address.
we  in  1  write enable.
di  in  DW  write data.
wmask  in  DW/MW  write lane enables; bit i enables di[i*MW +: MW].
init_done  out  1  high once array clear is complete; RAM is usable only when this is high.
pwrbus_ram_pd  in  32  power-down bus; functionally ignored.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values:
  - FSM state = INIT.
  - init counter = 0.
  - init_done = 0.
  - dout = 0, including all OREG stages.
  - The read-data register is cleared.
- FSM state INIT:
  - Each cycle writes all-zero to M[cnt], then cnt increments.
  - When the cycle with cnt == DEPTH-1 completes, go to READY and set init_done = 1 on the next cycle.
  - INIT lasts exactly DEPTH cycles after reset deasserts.
  - During INIT, we and re are ignored (no user writes, the read register is not updated) and dout stays 0.
- FSM state READY: persists until reset.
- Reset asserted at any time, including mid-INIT: the FSM returns to INIT with cnt = 0 and the full clear restarts.
- Write (READY):
  - we = 1 and wa < DEPTH: for each lane i with wmask[i] = 1, M[wa][lane i] <= di[lane i].
  - Lanes with wmask[i] = 0 keep their contents.
  - wmask = 0 means no change.
- Read (READY):
  - re = 1 and ra < DEPTH: the read register captures word ra at edge N.
  - dout shows it after edge N (OREG = 0) or after edge N+1 (OREG = 1).
  - re = 0: the read register holds its previous value, so dout is stable.
- Bypass, write-first:
  - re = 1, we = 1 and ra == wa in the same cycle: the captured word is M[ra] with the lanes enabled by wmask replaced by di.
  - This equals the post-write contents.
- Out of range (DEPTH < 2^AW):
  - A write with wa >= DEPTH is dropped.
  - A read with ra >= DEPTH captures all-zero.
- OREG = 1: stage 2 loads from stage 1 every cycle, which adds exactly one cycle of latency. Hold behaviour is preserved.
- No read/write contention assertion is required. Simultaneous read and write to different addresses are independent.
- Array storage: no reset besides the INIT sweep.

Test Plan:
- Init sweep (DEPTH = 128):
  - Hold reset for 2 cycles, release. init_done must rise exactly 128 cycles later.
  - Then read addresses 0..127: all return 0.
  - A we = 1 issued during INIT leaves the target word at 0.
- Basic R/W (OREG = 0):
  - Write di = 0xA5..A5 to wa = 5 with wmask all ones.
  - Next cycle, re with ra = 5: dout = 0xA5..A5 one cycle after the read edge.
  - dout holds while re = 0.
- Masked write:
  - Address 9 holds 0x11..11. Write di = 0xFF..FF with wmask = 0x0001.
  - A read of 9 returns 0x11..11FF (only lane 0 updated).
- Bypass:
  - Same cycle: we with wa = 3, di = 0xDEAD_BEEF (DW = 32), wmask = 0xC; re with ra = 3; old word 0x12345678.
  - dout = 0xDEAD5678.
- Reset mid-INIT:
  - Assert reset at cnt = 60 and release.
  - init_done stays low for a full 128 cycles. After init_done, a word written before the first reset reads as 0.
- Configuration (DEPTH = 100, AW = 7, OREG = 1):
  - A write to wa = 110 is dropped; a read of ra = 110 returns 0.
  - A valid read appears on dout exactly 2 cycles after the re edge.

Source files
------------

// File: rtl/nv_ram_rws_pinit.sv
// One-read/one-write single-clock RAM with lane write mask, write-first bypass,
// optional output register and a post-reset zeroing sweep.
module nv_ram_rws_pinit #(
  parameter int unsigned DW    = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned MW    = 8,
  parameter int unsigned OREG  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        ra,
  input  logic                 re,
  output logic [DW-1:0]        dout,
  input  logic [AW-1:0]        wa,
  input  logic                 we,
  input  logic [DW-1:0]        di,
  input  logic [DW/MW-1:0]     wmask,
  output logic                 init_done,
  input  logic [31:0]          pwrbus_ram_pd
);

  localparam int unsigned NL = DW / MW;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic [DW-1:0]    rd_q, rd_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             ra_ok, wa_ok;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NL-1:0]    wr_lanes;
  logic [DW-1:0]    rd_word;

  // Power bus only exists for interface compatibility.
  logic unused_pwr;
  assign unused_pwr = ^pwrbus_ram_pd;

  assign ra_ok = {1'b0, ra} < DEPTH_W;
  assign wa_ok = {1'b0, wa} < DEPTH_W;

  // Sequencer: sweep zeros through the array, then hand the write port to the user.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    wr_en       = 1'b0;
    wr_addr     = wa;
    wr_data     = di;
    wr_lanes    = wmask;
    case (state_q)
      ST_INIT: begin
        wr_en    = 1'b1;
        wr_addr  = cnt_q;
        wr_data  = '0;
        wr_lanes = '1;
        if (cnt_q == LAST) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_READY: wr_en = we & wa_ok;
      default:  state_d = ST_INIT;
    endcase
  end

  // Write-first read path: same-address write lanes override stored data.
  always_comb begin
    rd_word = '0;
    if (ra_ok) begin
      rd_word = mem_q[ra[IW-1:0]];
      if (we && (wa == ra)) begin
        for (int unsigned i = 0; i < NL; i++) begin
          if (wmask[i]) rd_word[i*MW +: MW] = di[i*MW +: MW];
        end
      end
    end
    rd_d = rd_q;
    if ((state_q == ST_READY) && re) rd_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_q        <= rd_d;
    end
  end

  // Storage has no reset; the sweep provides deterministic contents.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (wr_lanes[i]) mem_q[wr_addr[IW-1:0]][i*MW +: MW] <= wr_data[i*MW +: MW];
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] oreg_q, oreg_d;
      assign oreg_d = rd_q;
      always_ff @(posedge clk) begin
        if (reset) oreg_q <= '0;
        else       oreg_q <= oreg_d;
      end
      assign dout = oreg_q;
    end else begin : g_noreg
      assign dout = rd_q;
    end
  endgenerate

  assign init_done = init_done_q;

endmodule
